data_sram_like_ram: RTL
=======================

// Module: data_sram_like_ram
// PURPOSE
//  Responder (slave) for the CPU data-side sram-like interface (data_req/data_addr_ok/data_data_ok).
//  Word-organised RAM with byte-lane writes, fixed response latency and a bounded in-order
//  outstanding-request queue. Instantiated beside the instruction ROM in simulation benches.
//  Benches preload it through the hierarchical word array `ram`.
// PARAMETERS
//  ADDR_WIDTH  10  word-index bits; RAM holds 2**ADDR_WIDTH 32-bit words
//  LATENCY      2  cycles from address handshake to data_ok; legal range 1..8
//  DEPTH        2  maximum accepted-but-unanswered requests; legal range 1..8
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active-high
//  data_req      in   1   request valid
//  data_wr       in   1   1 = write, 0 = read
//  data_size     in   2   0 = byte, 1 = half, 2 = word, 3 = treated as word
//  data_addr     in   32  byte address
//  data_wdata    in   32  write data, lane-positioned (byte i on bits 8i+7:8i)
//  data_rdata    out  32  read data; valid while data_data_ok=1
//  data_addr_ok  out  1   request accepted this cycle when data_req=1
//  data_data_ok  out  1   one-cycle pulse per accepted request, in acceptance order
// BEHAVIOUR
//  Reset
//  - Values: data_addr_ok=0, data_data_ok=0, data_rdata=0; queue emptied.
//  - `ram` contents are NOT cleared.
//  - Asserting rst mid-operation drops every pending response.
//  - Writes accepted before reset stay committed.
//  Handshake and indexing
//  - data_addr_ok = !rst && (count < DEPTH). Combinational from registered count; no same-cycle
//    bypass when an entry retires.
//  - Handshake = data_req && data_addr_ok, sampled at posedge.
//  - At most one request is accepted per cycle.
//  - Word index = data_addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses alias.
//  Write byte lanes (a = data_addr[1:0])
//  - size 0: lane a.
//  - size 1: lanes {a[1],0} and {a[1],1}; a[0] is ignored.
//  - size 2 or 3: all four lanes; a is ignored.
//  - Writes commit to `ram` at the handshake edge.
//  Read data
//  - A read captures the full word at the handshake edge, after any write committing on that
//    same edge.
//  - data_rdata is unshifted; the CPU extracts the byte or half.
//  Queue
//  - Each entry holds {rdata, age}. Entries for writes return the data_ok only; data_rdata is
//    unchanged.
//  - age increments every cycle.
//  - Head retires when its age reaches LATENCY. Concretely, a handshake at edge N gives
//    data_data_ok=1 in the cycle after edge N+LATENCY-1.
//  - With LATENCY=1 that is the cycle immediately after the handshake cycle.
//  - Constant latency plus one acceptance per cycle gives at most one retire per cycle.
//    Responses keep acceptance order.
//  - data_rdata is registered. It updates only when a read retires and holds otherwise.
//  Count and throughput
//  - count = entries in the queue. A simultaneous accept and retire leaves count unchanged.
//  - count never exceeds DEPTH and never underflows.
//  - Throughput is one request per cycle when DEPTH >= LATENCY+1; otherwise addr_ok stalls.
//  - data_data_ok has no backpressure. The master must always take it.
//  - data_req dropped after a handshake does not affect pending responses.
// TESTING
//  - Word write/read: write 0xDEADBEEF at 0x100 (size 2), then read 0x100.
//    -> data_ok pulses 2 cycles after each handshake; rdata = 0xDEADBEEF.
//  - Byte and half lanes: preload 0x00000000 at 0x20. Write byte 0xAA at 0x21, then half
//    0x5566 at 0x22 (wdata=0x55660000). Read 0x20 -> 0x5566AA00.
//  - Streaming: 8 back-to-back reads with LATENCY=1, DEPTH=2 -> addr_ok held high,
//    8 consecutive data_ok pulses, data in address order.
//  - Stall: LATENCY=4, DEPTH=2. Issue 3 reads. -> addr_ok low after 2 handshakes; third
//    accepted the cycle after the first retires; count never exceeds 2.
//  - Reset mid-flight: 2 reads outstanding, pulse rst for 1 cycle. -> no data_ok afterwards.
//    A write accepted before reset reads back correctly after reset.
//  - Alias and RAW: write 0x12345678 at 0x0, then immediately read 0x1000 (ADDR_WIDTH=10,
//    aliases to 0x0). -> rdata = 0x12345678.

Source files
------------

// File: rtl/data_sram_like_ram.sv
// Data-side sram-like responder: word RAM with byte-lane writes, fixed response
// latency and an in-order queue of at most DEPTH accepted-but-unanswered requests.
module data_sram_like_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2,
   parameter int DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok
);
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]    LAT_C   = 4'(LATENCY);

   typedef struct packed {
      logic [31:0] rdata;
      logic        rd;
      logic [3:0]  age;
   } ent_t;

   logic [31:0]           ram [2**ADDR_WIDTH];
   ent_t                  q_q [DEPTH];
   ent_t                  q_d [DEPTH];
   logic [CW-1:0]         count_q, count_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  hs, retire;
   logic [ADDR_WIDTH-1:0] idx;
   logic [3:0]            be;
   logic                  unused_addr;

   assign idx          = data_addr[ADDR_WIDTH+1:2];
   assign unused_addr  = ^data_addr[31:ADDR_WIDTH+2];
   assign data_addr_ok = !rst && (count_q < DEPTH_C);
   assign hs           = data_req && data_addr_ok;
   assign retire       = (count_q != '0) && (q_q[0].age == LAT_C);
   assign data_data_ok = retire;
   // The retiring head is presented directly; rdata_q holds it afterwards.
   assign data_rdata   = (retire && q_q[0].rd) ? q_q[0].rdata : rdata_q;

   always_comb begin
      case (data_size)
         2'd0:    be = 4'b0001 << data_addr[1:0];
         2'd1:    be = data_addr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (hs && data_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram[idx][8*b +: 8] <= data_wdata[8*b +: 8];
         end
      end
   end

   // Shift-register queue, head at index 0; every slot ages each cycle.
   always_comb begin
      int src;
      int wr_idx;
      for (int i = 0; i < DEPTH; i++) begin
         src = retire ? i + 1 : i;
         if (src > DEPTH - 1) src = DEPTH - 1;
         q_d[i]     = q_q[src];
         q_d[i].age = q_q[src].age + 4'd1;
      end
      wr_idx = int'(count_q) - (retire ? 1 : 0);
      if (hs) begin
         q_d[wr_idx].rdata = ram[idx];
         q_d[wr_idx].rd    = !data_wr;
         q_d[wr_idx].age   = 4'd1;
      end
      count_d = count_q;
      if (hs && !retire) count_d = count_q + CW'(1);
      if (!hs && retire) count_d = count_q - CW'(1);
      rdata_d = (retire && q_q[0].rd) ? q_q[0].rdata : rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         rdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      end else begin
         count_q <= count_d;
         rdata_q <= rdata_d;
         q_q     <= q_d;
      end
   end
endmodule
